// File: rtl/mole_timer_bank.sv
// mole_timer_bank: shared tick prescaler plus NUM_CH independent countdown channels.
// Each channel runs IDLE -> RUN -> DONE, counting game ticks from a per-load duration,
// and reports running, timeout (level) and a one-cycle expire pulse.
// Optional feature macro: TIMER_AUTORELOAD_EN adds autoreload_i and per-channel reload
// registers so an expiring channel can restart itself instead of going to DONE.
module mole_timer_bank #(
    parameter int unsigned CLOCK_FREQ = 30_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pause_i,
    input  logic [NUM_CH-1:0] load_i,
    input  logic [CNT_W-1:0]  load_val_i,
    input  logic [NUM_CH-1:0] stop_i,
`ifdef TIMER_AUTORELOAD_EN
    input  logic [NUM_CH-1:0] autoreload_i,
`endif
    output logic              tick_o,
    output logic [NUM_CH-1:0] running_o,
    output logic [NUM_CH-1:0] timeout_o,
    output logic [NUM_CH-1:0] expire_o
);

    localparam int unsigned DIV   = CLOCK_FREQ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PreLast = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PreNext = PRE_W'(DIV - 2);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ch_state_e;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             tick_en;

    // tick_q tracks (pre_q == DIV-1) as a register; it holds with pre while paused.
    always_comb begin
        pre_d  = pre_q;
        tick_d = tick_q;
        if (!pause_i) begin
            pre_d  = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
            tick_d = (pre_q == PreNext);
        end
    end

    // Prescaler state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // A paused cycle sitting on the terminal count must not count as a tick.
    assign tick_en = tick_q & ~pause_i;
    assign tick_o  = tick_en;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] expire_q, expire_d;
`ifdef TIMER_AUTORELOAD_EN
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
`endif

    // Per-channel next state; priority is load > stop > tick-decrement.
    always_comb begin
        expire_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef TIMER_AUTORELOAD_EN
            reload_d[i] = reload_q[i];
`endif
            if (load_i[i]) begin
`ifdef TIMER_AUTORELOAD_EN
                reload_d[i] = load_val_i;
`endif
                if (load_val_i != '0) begin
                    state_d[i] = StRun;
                    cnt_d[i]   = load_val_i;
                end else begin
                    // Zero duration expires on the load edge itself.
                    state_d[i]  = StDone;
                    cnt_d[i]    = '0;
                    expire_d[i] = 1'b1;
                end
            end else if (stop_i[i]) begin
                state_d[i] = StIdle;
            end else if (state_q[i] == StRun && tick_en) begin
                if (cnt_q[i] > CNT_W'(1)) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    expire_d[i] = 1'b1;
                    cnt_d[i]    = '0;
                    state_d[i]  = StDone;
`ifdef TIMER_AUTORELOAD_EN
                    if (autoreload_i[i] && reload_q[i] != '0) begin
                        cnt_d[i]   = reload_q[i];
                        state_d[i] = StRun;
                    end
`endif
                end
            end
        end
    end

    // Channel state, counters and expire pulses with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            expire_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
`ifdef TIMER_AUTORELOAD_EN
                reload_q[i] <= '0;
`endif
            end
        end else begin
            expire_q <= expire_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef TIMER_AUTORELOAD_EN
                reload_q[i] <= reload_d[i];
`endif
            end
        end
    end

    // Status outputs decode straight from the registered channel state.
    always_comb begin
        running_o = '0;
        timeout_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            running_o[i] = (state_q[i] == StRun);
            timeout_o[i] = (state_q[i] == StDone);
        end
    end

    assign expire_o = expire_q;

endmodule

// File: tb/tb_mole_timer_bank.sv
// Testbench for mole_timer_bank: directed scenarios plus random traffic, all outputs
// compared every cycle against a tick-counting reference model.
module tb_mole_timer_bank;

    localparam int DIV = 8;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           pause;
    logic [NCH-1:0] load;
    logic [CW-1:0]  load_val;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] autoreload;
    logic           tick;
    logic [NCH-1:0] running;
    logic [NCH-1:0] timeout;
    logic [NCH-1:0] expire;

    mole_timer_bank #(
        .CLOCK_FREQ(8),
        .TICK_HZ   (1),
        .NUM_CH    (NCH),
        .CNT_W     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pause_i     (pause),
        .load_i      (load),
        .load_val_i  (load_val),
        .stop_i      (stop),
`ifdef TIMER_AUTORELOAD_EN
        .autoreload_i(autoreload),
`endif
        .tick_o      (tick),
        .running_o   (running),
        .timeout_o   (timeout),
        .expire_o    (expire)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: ticks from a count of unpaused cycles, channels as remaining ticks.
    int           ucnt;
    int           m_mode   [NCH];
    int           m_cnt    [NCH];
    int           m_reload [NCH];
    bit [NCH-1:0] m_exp;
    bit           m_valid = 1'b0;

    logic           obs_tick;
    logic [NCH-1:0] obs_run, obs_to, obs_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [NCH-1:0] mode_vec(input int m);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_mode[i] == m);
        return v;
    endfunction

    task automatic model_step();
        bit t;
        int lv;
        if (rst) begin
            m_valid = 1'b1;
            ucnt    = 0;
            m_exp   = '0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = MIdle; m_cnt[i] = 0; m_reload[i] = 0;
            end
        end else begin
            t  = !pause && (ucnt % DIV == DIV - 1);
            lv = int'(load_val);
            if (!pause) ucnt++;
            for (int i = 0; i < NCH; i++) begin
                m_exp[i] = 1'b0;
                if (load[i]) begin
                    m_reload[i] = lv;
                    if (lv != 0) begin
                        m_mode[i] = MRun; m_cnt[i] = lv;
                    end else begin
                        m_mode[i] = MDone; m_cnt[i] = 0; m_exp[i] = 1'b1;
                    end
                end else if (stop[i]) begin
                    m_mode[i] = MIdle;
                end else if (m_mode[i] == MRun && t) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_exp[i] = 1'b1;
                        if (autoreload[i] && m_reload[i] != 0) m_cnt[i] = m_reload[i];
                        else m_mode[i] = MDone;
                    end
                end
            end
        end
    endtask

    // One clock: sample and check at negedge, advance the model at posedge.
    task automatic cycle();
        @(negedge clk);
        obs_tick = tick;
        obs_run  = running;
        obs_to   = timeout;
        obs_exp  = expire;
        if (m_valid) begin
            chk("tick", 32'(obs_tick), 32'(!pause && (ucnt % DIV == DIV - 1)));
            chk("running", 32'(obs_run), 32'(mode_vec(MRun)));
            chk("timeout", 32'(obs_to), 32'(mode_vec(MDone)));
            chk("expire", 32'(obs_exp), 32'(m_exp));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Runs until a tick cycle has completed, so the next cycle starts a tick period.
    task automatic wait_tick();
        bit found = 1'b0;
        int n = 0;
        while (!found && n < 2 * DIV) begin
            cycle();
            n++;
            found = (obs_tick === 1'b1);
        end
        chk("wait_tick", 32'(found), 32'd1);
    endtask

    // Advances until expire[ch] is seen, k counting cycles since the load cycle.
    task automatic wait_exp(input int ch, inout int k);
        bit found = 1'b0;
        int lim = k + 200;
        while (!found && k < lim) begin
            cycle();
            k++;
            found = (obs_exp[ch] === 1'b1);
        end
        chk($sformatf("exp_seen_ch%0d", ch), 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int prev;
        rst = 1'b1; pause = 1'b0; load = '0; stop = '0; load_val = '0; autoreload = '0;
        #1;

        // Reset and first tick
        repeat (3) cycle();
        chk("reset_outputs", 32'({obs_tick, obs_run, obs_to, obs_exp}), 32'd0);
        rst = 1'b0;
        k = 0;
        cycle();
        while (obs_tick !== 1'b1 && k < 20) begin
            cycle();
            k++;
        end
        chk("first_tick_cycle", 32'(k), 32'd7);

        // Basic countdown, loaded right after a tick
        load = 4'b0001; load_val = 8'd3;
        cycle();
        load = '0;
        cycle();
        chk("run_after_load", 32'(obs_run[0]), 32'd1);
        k = 1;
        wait_exp(0, k);
        chk("basic_expire_time", 32'(k), 32'd24);
        cycle();
        chk("basic_expire_single", 32'(obs_exp[0]), 32'd0);
        chk("basic_timeout", 32'(obs_to[0]), 32'd1);
        chk("basic_not_running", 32'(obs_run[0]), 32'd0);

        // Zero load expires on the load edge
        load = 4'b0010; load_val = 8'd0;
        cycle();
        load = '0;
        cycle();
        chk("zero_timeout", 32'(obs_to[1]), 32'd1);
        chk("zero_expire", 32'(obs_exp[1]), 32'd1);

        // Retrigger after two ticks
        wait_tick();
        load = 4'b0100; load_val = 8'd5;
        cycle();
        load = '0;
        wait_tick();
        wait_tick();
        load = 4'b0100; load_val = 8'd5;
        cycle();
        load = '0;
        k = 0;
        wait_exp(2, k);
        chk("retrigger_expire_time", 32'(k), 32'd40);

        // Pause mid-count delays expiry by the pause length
        wait_tick();
        load = 4'b1000; load_val = 8'd4;
        cycle();
        load = '0;
        repeat (10) cycle();
        pause = 1'b1;
        repeat (20) cycle();
        pause = 1'b0;
        k = 30;
        wait_exp(3, k);
        chk("pause_expire_time", 32'(k), 32'd52);

        // Stop coinciding with the final tick
        wait_tick();
        load = 4'b0001; load_val = 8'd1;
        cycle();
        load = '0;
        repeat (6) cycle();
        stop = 4'b0001;
        cycle();
        chk("stop_on_tick", 32'(obs_tick), 32'd1);
        chk("stop_was_running", 32'(obs_run[0]), 32'd1);
        stop = '0;
        cycle();
        chk("stop_no_expire", 32'(obs_exp[0]), 32'd0);
        chk("stop_idle", 32'({obs_run[0], obs_to[0]}), 32'd0);

        // Simultaneous expiry on all channels
        wait_tick();
        load = 4'b1111; load_val = 8'd2;
        cycle();
        load = '0;
        k = 0;
        cycle();
        k++;
        while (obs_exp === 4'b0000 && k < 40) begin
            cycle();
            k++;
        end
        chk("simul_expire_bits", 32'(obs_exp), 32'hF);
        chk("simul_expire_time", 32'(k), 32'd16);

        // Reset during RUN
        load = 4'b1111; load_val = 8'd3;
        cycle();
        load = '0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_run_cleared", 32'({obs_run, obs_to, obs_exp}), 32'd0);
        repeat (30) cycle();

`ifdef TIMER_AUTORELOAD_EN
        // Autoreload keeps channel 0 in RUN with a fixed expire period
        wait_tick();
        autoreload = 4'b0001;
        load = 4'b0001; load_val = 8'd2;
        cycle();
        load = '0;
        k = 0;
        prev = 0;
        for (int p = 0; p < 4; p++) begin
            wait_exp(0, k);
            chk("autoreload_period", 32'(k - prev), 32'd16);
            chk("autoreload_no_timeout", 32'(obs_to[0]), 32'd0);
            prev = k;
        end
        autoreload = '0;
        stop = 4'b0001;
        cycle();
        stop = '0;
`else
        prev = 0;
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 249) == 0);
            pause = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NCH; i++) begin
                load[i] = ($urandom_range(0, 15) == 0);
                stop[i] = ($urandom_range(0, 31) == 0);
            end
            load_val = CW'($urandom_range(0, 4));
`ifdef TIMER_AUTORELOAD_EN
            autoreload = NCH'($urandom);
`endif
            cycle();
        end
        rst = 1'b0; pause = 1'b0; load = '0; stop = '0;
        repeat (40) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
